// File: rtl/param_bypass_fifo.sv
`default_nettype none
// ============================================================================
// Module      : param_bypass_fifo
// Description : Parameterised synchronous FIFO with optional zero-latency
//               bypass, registered-address storage and write-to-read forwarding.
// Revision    : 1.0 - initial release
// ============================================================================
module param_bypass_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10,
    parameter int BYPASS     = 1,
    parameter int AF_THR     = DEPTH - 2,
    parameter int AE_THR     = 1
) (
    input  logic                         clock_port,
    input  logic                         reset_port,
    input  logic                         clear,
    input  logic [DATA_WIDTH-1:0]        input_port_data,
    input  logic                         input_port_valid,
    output logic                         input_port_ready,
    output logic [DATA_WIDTH-1:0]        output_port_data,
    output logic                         output_port_valid,
    input  logic                         output_port_ready,
    output logic [$clog2(DEPTH+1)-1:0]   level,
    output logic                         almost_full,
    output logic                         almost_empty
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] c_depth     = LW'(DEPTH);
    localparam logic [LW-1:0] c_af_thr    = LW'(AF_THR);
    localparam logic [LW-1:0] c_ae_thr    = LW'(AE_THR);
    localparam logic [PW-1:0] c_last_ptr  = PW'(DEPTH - 1);
    localparam bit            c_bypass_en = (BYPASS != 0);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic [DATA_WIDTH-1:0] r_fwd_data;
    logic                  r_fwd;
    logic [PW-1:0]         r_push_ptr;
    logic [PW-1:0]         r_pop_ptr;
    logic [LW-1:0]         r_level;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_af;
    logic                  r_ae;

    logic                  w_bypass;
    logic                  w_push;
    logic                  w_pop;
    logic [PW-1:0]         w_push_ptr_nxt;
    logic [PW-1:0]         w_pop_ptr_nxt;
    logic [LW-1:0]         w_level_nxt;
    logic [DATA_WIDTH-1:0] w_head;

    assign input_port_ready = ~r_full & ~clear;
    assign w_bypass = c_bypass_en & r_empty & input_port_valid & output_port_ready
                    & ~clear & ~r_full;
    assign w_push   = input_port_valid & input_port_ready & ~w_bypass;
    assign w_pop    = ~r_empty & output_port_ready & ~clear;

    always_comb begin
        w_push_ptr_nxt = r_push_ptr;
        w_pop_ptr_nxt  = r_pop_ptr;
        if (!reset_port || clear) begin
            w_push_ptr_nxt = '0;
            w_pop_ptr_nxt  = '0;
        end else begin
            if (w_push)
                w_push_ptr_nxt = (r_push_ptr == c_last_ptr) ? '0 : r_push_ptr + PW'(1);
            if (w_pop)
                w_pop_ptr_nxt = (r_pop_ptr == c_last_ptr) ? '0 : r_pop_ptr + PW'(1);
        end
    end

    always_comb begin
        w_level_nxt = r_level;
        if (w_push && !w_pop)
            w_level_nxt = r_level + LW'(1);
        else if (!w_push && w_pop)
            w_level_nxt = r_level - LW'(1);
    end

    always_ff @(posedge clock_port) begin
        if (!reset_port || clear) begin
            r_push_ptr <= '0;
            r_pop_ptr  <= '0;
            r_level    <= '0;
            r_empty    <= 1'b1;
            r_full     <= 1'b0;
            r_af       <= 1'b0;
            r_ae       <= 1'b1;
            r_fwd      <= 1'b0;
        end else begin
            r_push_ptr <= w_push_ptr_nxt;
            r_pop_ptr  <= w_pop_ptr_nxt;
            r_level    <= w_level_nxt;
            r_empty    <= (w_level_nxt == '0);
            r_full     <= (w_level_nxt == c_depth);
            r_af       <= (w_level_nxt >= c_af_thr);
            r_ae       <= (w_level_nxt <= c_ae_thr);
            // Storage reads old data on a same-address write, so remember the new word.
            r_fwd      <= w_push && (r_push_ptr == w_pop_ptr_nxt);
        end
    end

    always_ff @(posedge clock_port) begin
        if (w_push) begin
            r_mem[r_push_ptr] <= input_port_data;
            r_fwd_data        <= input_port_data;
        end
        r_rd_data <= r_mem[w_pop_ptr_nxt];
    end

    assign w_head            = r_fwd ? r_fwd_data : r_rd_data;
    assign output_port_data  = w_bypass ? input_port_data : w_head;
    assign output_port_valid = (~r_empty | w_bypass) & ~clear;
    assign level             = r_level;
    assign almost_full       = r_af;
    assign almost_empty      = r_ae;

endmodule
`default_nettype wire

// File: tb/tb_param_bypass_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_param_bypass_fifo
// Description : Directed vector bench for param_bypass_fifo (bypass and
//               non-bypass instances).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_param_bypass_fifo;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // Instance A: defaults (DEPTH 10, BYPASS 1, AF 8, AE 1)
    logic       a_rst_n, a_clr, a_iv, a_irdy, a_ov, a_ordy, a_af, a_ae;
    logic [7:0] a_id, a_od;
    logic [3:0] a_lvl;

    // Instance B: BYPASS 0
    logic       b_rst_n, b_clr, b_iv, b_irdy, b_ov, b_ordy, b_af, b_ae;
    logic [7:0] b_id, b_od;
    logic [3:0] b_lvl;

    param_bypass_fifo u_dut_a (
        .clock_port        (clk),
        .reset_port        (a_rst_n),
        .clear             (a_clr),
        .input_port_data   (a_id),
        .input_port_valid  (a_iv),
        .input_port_ready  (a_irdy),
        .output_port_data  (a_od),
        .output_port_valid (a_ov),
        .output_port_ready (a_ordy),
        .level             (a_lvl),
        .almost_full       (a_af),
        .almost_empty      (a_ae)
    );

    param_bypass_fifo #(.BYPASS(0)) u_dut_b (
        .clock_port        (clk),
        .reset_port        (b_rst_n),
        .clear             (b_clr),
        .input_port_data   (b_id),
        .input_port_valid  (b_iv),
        .input_port_ready  (b_irdy),
        .output_port_data  (b_od),
        .output_port_valid (b_ov),
        .output_port_ready (b_ordy),
        .level             (b_lvl),
        .almost_full       (b_af),
        .almost_empty      (b_ae)
    );

    typedef struct {
        logic       rst_n, clr, iv;
        logic [7:0] id;
        logic       ordy;
        logic       e_irdy, e_ov;
        logic [7:0] e_od;
        logic [3:0] e_lvl;
        logic       e_af, e_ae;
    } vec_t;

    vec_t vecs[$];
    int   checks = 0;
    int   errors = 0;

    task automatic add(input logic rst_n, input logic clr, input logic iv,
                       input logic [7:0] id, input logic ordy,
                       input logic e_irdy, input logic e_ov, input logic [7:0] e_od,
                       input int e_lvl);
        vec_t v;
        v.rst_n = rst_n; v.clr = clr; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_irdy = e_irdy; v.e_ov = e_ov; v.e_od = e_od; v.e_lvl = 4'(e_lvl);
        v.e_af = (e_lvl >= 8);
        v.e_ae = (e_lvl <= 1);
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model_q[$];
    int         sent, rcvd, cyc;
    logic [7:0] exp_w;

    initial begin
        a_rst_n = 1'b0; a_clr = 1'b0; a_iv = 1'b0; a_id = '0; a_ordy = 1'b0;
        b_rst_n = 1'b0; b_clr = 1'b0; b_iv = 1'b0; b_id = '0; b_ordy = 1'b0;
        repeat (2) next_cycle();
        b_rst_n = 1'b1;

        // ---- vector table for instance A ----
        add(0, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);           // reset state
        add(1, 0, 1, 8'hA5, 1, 1, 1, 8'hA5, 0);           // bypass
        add(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);           // level untouched
        for (int k = 0; k < 10; k++)                      // fill 0x00..0x09
            add(1, 0, 1, 8'(k), 0, 1, (k > 0), 8'h00, k);
        add(1, 0, 1, 8'h0A, 0, 0, 1, 8'h00, 10);          // full, refused
        add(1, 0, 1, 8'h0B, 1, 0, 1, 8'h00, 10);          // full: pop only
        add(1, 0, 1, 8'h0B, 0, 1, 1, 8'h01, 9);           // ready again, write
        add(1, 0, 0, 8'h00, 0, 0, 1, 8'h01, 10);
        for (int k = 0; k < 10; k++)                      // drain
            add(1, 0, 0, 8'h00, 1, (k > 0), 1, (k < 9) ? 8'(k + 1) : 8'h0B, 10 - k);
        add(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);
        for (int k = 0; k < 5; k++)                       // level 5
            add(1, 0, 1, 8'(8'h20 + k), 0, 1, (k > 0), 8'h20, k);
        add(1, 1, 1, 8'h55, 1, 0, 0, 8'h00, 5);           // clear cycle
        add(1, 0, 0, 8'h00, 1, 1, 0, 8'h00, 0);
        add(1, 0, 1, 8'h66, 1, 1, 1, 8'h66, 0);           // no stale word
        add(1, 0, 0, 8'h00, 0, 1, 0, 8'h00, 0);

        foreach (vecs[i]) begin
            a_rst_n = vecs[i].rst_n; a_clr = vecs[i].clr; a_iv = vecs[i].iv;
            a_id = vecs[i].id; a_ordy = vecs[i].ordy;
            @(negedge clk);
            chk($sformatf("v%0d_irdy", i), 32'(a_irdy), 32'(vecs[i].e_irdy));
            chk($sformatf("v%0d_ov", i),   32'(a_ov),   32'(vecs[i].e_ov));
            if (vecs[i].e_ov)
                chk($sformatf("v%0d_od", i), 32'(a_od), 32'(vecs[i].e_od));
            chk($sformatf("v%0d_lvl", i),  32'(a_lvl),  32'(vecs[i].e_lvl));
            chk($sformatf("v%0d_af", i),   32'(a_af),   32'(vecs[i].e_af));
            chk($sformatf("v%0d_ae", i),   32'(a_ae),   32'(vecs[i].e_ae));
            next_cycle();
        end

        // ---- streaming 25 words with random consumer stalls ----
        sent = 0; rcvd = 0; cyc = 0;
        while (rcvd < 25 && cyc < 1000) begin
            a_iv   = (sent < 25);
            a_id   = 8'(8'h40 + sent);
            a_ordy = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (a_iv && a_irdy) begin
                model_q.push_back(a_id);
                sent++;
            end
            if (a_ov && a_ordy) begin
                if (model_q.size() == 0) begin
                    chk("stream_spurious", 32'(a_od), 32'hFFFF_FFFF);
                end else begin
                    exp_w = model_q.pop_front();
                    chk($sformatf("stream_w%0d", rcvd), 32'(a_od), 32'(exp_w));
                end
                rcvd++;
            end
            cyc++;
            next_cycle();
        end
        chk("stream_done", 32'(rcvd), 32'd25);
        a_iv = 1'b0; a_ordy = 1'b0;

        // ---- instance B: no bypass, one-cycle latency, mid-stream reset ----
        b_iv = 1'b1; b_id = 8'h3C; b_ordy = 1'b1;
        @(negedge clk);
        chk("b_nobypass_ov", 32'(b_ov), 32'd0);
        chk("b_first_irdy", 32'(b_irdy), 32'd1);
        next_cycle();
        b_iv = 1'b0;
        @(negedge clk);
        chk("b_fwd_ov", 32'(b_ov), 32'd1);
        chk("b_fwd_od", 32'(b_od), 32'h3C);
        chk("b_fwd_lvl", 32'(b_lvl), 32'd1);
        next_cycle();
        @(negedge clk);
        chk("b_empty_ov", 32'(b_ov), 32'd0);
        chk("b_empty_lvl", 32'(b_lvl), 32'd0);
        next_cycle();
        b_ordy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            b_iv = 1'b1; b_id = 8'(8'h71 + k);
            next_cycle();
        end
        b_iv = 1'b0; b_rst_n = 1'b0;
        @(negedge clk);
        chk("b_prerst_lvl", 32'(b_lvl), 32'd3);
        chk("b_prerst_od", 32'(b_od), 32'h71);
        next_cycle();
        b_rst_n = 1'b1;
        @(negedge clk);
        chk("b_rst_lvl", 32'(b_lvl), 32'd0);
        chk("b_rst_ov", 32'(b_ov), 32'd0);
        chk("b_rst_irdy", 32'(b_irdy), 32'd1);
        chk("b_rst_ae", 32'(b_ae), 32'd1);
        chk("b_rst_af", 32'(b_af), 32'd0);
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
